chip_test_sequencer: RTL and testbench
======================================

# chip_test_sequencer

Front-end controller for the chip-checker tester modules. It turns the raw Start pushbutton into a single clean `Run` pulse for the selected checker, then waits for the checker's `Done`. It latches the checker's `RSLT` (or flags a timeout) and drives `DISP_RSLT` back so the checker presents its result. It also keeps saturating pass/fail tallies for the board LEDs and hex display.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: maximum number of cycles in WAIT before a timeout (20 ms at 50 MHz).
- `SYNC_STAGES`, default 2: number of flip-flops in the Start and Clear synchronizers.
- `CNT_W`, default 8: width of the pass and fail counters.

Ports:
- `Clk`  in  1  system clock; single clock domain.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  asynchronous pushbutton, active-high; a new test begins on its rising edge.
- `Clear`  in  1  asynchronous pushbutton, active-high; zeroes the tallies.
- `Done`  in  1  checker completion flag; held high until the checker's next `Run`.
- `RSLT`  in  1  checker result (1 = pass); valid while `Done` and `DISP_RSLT` are both high.
- `Run`  out  1  one-cycle start pulse to the checker.
- `DISP_RSLT`  out  1  asks the checker to present `RSLT`.
- `Busy`  out  1  high in ARM, RUN and WAIT.
- `Pass`  out  1  latched result of the last test: pass.
- `Fail`  out  1  latched result of the last test: fail.
- `Timeout`  out  1  latched result of the last test: no `Done` within `TIMEOUT_CYCLES`.
- `PassCnt`  out  `CNT_W`  saturating count of passed tests.
- `FailCnt`  out  `CNT_W`  saturating count of failed and timed-out tests.

## Operation
- `Start` and `Clear` each pass through a `SYNC_STAGES` synchronizer, then a rising-edge detector. Each detector produces a one-cycle `start_evt` or `clr_evt`.
- State machine:
  - IDLE: outputs quiet. `start_evt` → ARM.
  - ARM: clears `Pass`, `Fail` and `Timeout`; loads the timeout counter with `TIMEOUT_CYCLES-1`. Always → RUN.
  - RUN: `Run`=1 for exactly this cycle. Always → WAIT.
  - WAIT: `DISP_RSLT`=1. `Done` is ignored in the first WAIT cycle, because a stale `Done` may still be high from the previous test. From the second cycle on:
    - `Done`=1 → SHOW, latching `Pass`=`RSLT` and `Fail`=~`RSLT`.
    - Otherwise the counter decrements; at 0 → SHOW with `Timeout`=1.
  - SHOW: `DISP_RSLT`=1 and the result flags are held. `start_evt` → ARM (re-run).
- Events in SHOW: `clr_evt` zeroes both counters and leaves the flags intact.
- Counter updates:
  - On WAIT→SHOW, `PassCnt` increments on a pass; `FailCnt` increments on a fail or timeout.
  - Both counters saturate at 2^`CNT_W`-1; they never wrap.
- Events ignored:
  - `start_evt` in ARM, RUN or WAIT.
  - `clr_evt` in ARM, RUN or WAIT.
- Priorities:
  - If `Done` arrives in the same cycle the timeout counter reaches 0, `Done` wins: a normal result, no timeout.
  - If `Clear` and `Start` events coincide in SHOW, clear first, then ARM.

## Timing
- Reset values: state=IDLE; `Run`, `DISP_RSLT`, `Busy`, `Pass`, `Fail` and `Timeout` all 0; `PassCnt` and `FailCnt` both 0. Synchronizer and edge-detector flops also clear.
- Reset mid-test: all of the above take effect on the next edge. `Run` can never be truncated to zero cycles or stretched beyond one.
- Start latency: the raw `Start` rising edge to `start_evt` takes `SYNC_STAGES`+1 cycles. `Run` is high 2 cycles after `start_evt` (ARM, then RUN).
- Done latency: `Done` sampled high in WAIT → SHOW and flags valid on the next cycle. The counters update on the same edge.
- Worst-case WAIT duration: `TIMEOUT_CYCLES` cycles.
- Output registration: all outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Package `chip_test_pkg`:
  - `seq_state_t` enum: IDLE, ARM, RUN, WAIT, SHOW.
  - `DEFAULT_TIMEOUT` constant.
  - `RESULT_PASS` / `RESULT_FAIL` encodings, shared with the checker modules.
- One sub-module, `sync_edge_detect`, parameterised by `SYNC_STAGES`. It is instantiated twice, once for `Start` and once for `Clear`.

## Test plan
- Reset, then hold 10 cycles → every output 0 and state IDLE.
- `Start` pulse; checker model raises `Done` 5 cycles after `Run` with `RSLT`=1 → exactly one `Run` cycle, `Pass`=1, `PassCnt`=1, `DISP_RSLT` held high.
- `Start` pulse with `Done` never asserted, `TIMEOUT_CYCLES`=16 → `Timeout`=1 exactly 16 cycles after entering WAIT, and `FailCnt`=1.
- `Done` stuck high from a previous run, then new `Start` → first WAIT cycle ignored; result latched from the second cycle onward.
- Run 260 passing tests with `CNT_W`=8 → `PassCnt` saturates at 255. Then `Clear` in SHOW → `PassCnt`=0 and `FailCnt`=0, with `Pass` still 1.
- Assert `Reset` during WAIT, then release → IDLE, flags and counters 0, no spurious `Run`. Also: `Start` pressed during WAIT is ignored.

Source files
------------

// File: rtl/chip_test_pkg.sv
// Shared types and constants for the chip-checker front-end sequencer
// and the checker modules it drives.
package chip_test_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        WAIT,
        SHOW
    } seq_state_t;

    // 20 ms at 50 MHz
    localparam int unsigned DEFAULT_TIMEOUT = 1_000_000;

    localparam logic RESULT_PASS = 1'b1;
    localparam logic RESULT_FAIL = 1'b0;

endpackage

// File: rtl/chip_test_sequencer_if.sv
// Handshake between the sequencer (master) and a chip checker (slave).
interface chip_test_sequencer_if;

    logic Run;
    logic DISP_RSLT;
    logic Done;
    logic RSLT;

    modport master (output Run, output DISP_RSLT, input Done, input RSLT);
    modport slave  (input Run, input DISP_RSLT, output Done, output RSLT);

endinterface

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous pushbutton and emits a registered one-cycle
// pulse on its rising edge (SYNC_STAGES+1 cycles after the raw edge).
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic evt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            evt    <= 1'b0;
        end else begin
            sync_q[0] <= din;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
            evt    <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/chip_test_sequencer.sv
// Start/Done sequencer for the chip checkers: issues one Run pulse per Start
// press, latches the result or a timeout, and keeps saturating tallies.
module chip_test_sequencer
    import chip_test_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic                    Clear,
    chip_test_sequencer_if.master   chk,
    output logic                    Busy,
    output logic                    Pass,
    output logic                    Fail,
    output logic                    Timeout,
    output logic [CNT_W-1:0]        PassCnt,
    output logic [CNT_W-1:0]        FailCnt
);

    localparam int unsigned      TMR_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    seq_state_t       state, next_state;
    logic             start_evt, clr_evt;
    logic [TMR_W-1:0] tmr;
    logic             wait_first;
    logic             done_ok, tmr_expired;
    logic             run_d, disp_d, busy_d;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_start_sync (
        .clk (Clk),
        .rst (Reset),
        .din (Start),
        .evt (start_evt)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_clear_sync (
        .clk (Clk),
        .rst (Reset),
        .din (Clear),
        .evt (clr_evt)
    );

    // A stale Done from the previous test can still be high in the first WAIT cycle
    assign done_ok     = (state == WAIT) && !wait_first && chk.Done;
    assign tmr_expired = (state == WAIT) && (tmr == '0);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            chk.Run       <= 1'b0;
            chk.DISP_RSLT <= 1'b0;
            Busy          <= 1'b0;
        end else begin
            state         <= next_state;
            chk.Run       <= run_d;
            chk.DISP_RSLT <= disp_d;
            Busy          <= busy_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_evt) next_state = ARM;
            ARM:     next_state = RUN;
            RUN:     next_state = WAIT;
            WAIT:    if (done_ok || tmr_expired) next_state = SHOW;
            SHOW:    if (start_evt) next_state = ARM;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from next_state so they arrive registered with the state
    always_comb begin
        run_d  = (next_state == RUN);
        disp_d = (next_state inside {WAIT, SHOW});
        busy_d = (next_state inside {ARM, RUN, WAIT});
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            tmr        <= '0;
            wait_first <= 1'b0;
            Pass       <= 1'b0;
            Fail       <= 1'b0;
            Timeout    <= 1'b0;
            PassCnt    <= '0;
            FailCnt    <= '0;
        end else begin
            wait_first <= (state == RUN);
            case (state)
                ARM: begin
                    Pass    <= 1'b0;
                    Fail    <= 1'b0;
                    Timeout <= 1'b0;
                    tmr     <= TMR_LOAD;
                end
                WAIT: begin
                    if (done_ok) begin
                        Pass <= (chk.RSLT == RESULT_PASS);
                        Fail <= (chk.RSLT == RESULT_FAIL);
                        if (chk.RSLT == RESULT_PASS) begin
                            if (PassCnt != CNT_MAX) PassCnt <= PassCnt + 1'b1;
                        end else begin
                            if (FailCnt != CNT_MAX) FailCnt <= FailCnt + 1'b1;
                        end
                    end else if (tmr_expired) begin
                        Timeout <= 1'b1;
                        if (FailCnt != CNT_MAX) FailCnt <= FailCnt + 1'b1;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                IDLE, SHOW: begin
                    if (clr_evt) begin
                        PassCnt <= '0;
                        FailCnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chip_test_sequencer.sv
// Scoreboard bench for chip_test_sequencer with a behavioural checker model.
module tb_chip_test_sequencer;
    import chip_test_pkg::*;

    localparam int unsigned TMO     = 16;
    localparam int unsigned CW      = 8;
    localparam int          CNT_TOP = (1 << CW) - 1;

    logic          clk, rst, start, clear;
    logic          busy, pass, fail, tmo;
    logic [CW-1:0] pass_cnt, fail_cnt;

    chip_test_sequencer_if cif();

    chip_test_sequencer #(
        .TIMEOUT_CYCLES (TMO),
        .SYNC_STAGES    (2),
        .CNT_W          (CW)
    ) dut (
        .Clk     (clk),
        .Reset   (rst),
        .Start   (start),
        .Clear   (clear),
        .chk     (cif.master),
        .Busy    (busy),
        .Pass    (pass),
        .Fail    (fail),
        .Timeout (tmo),
        .PassCnt (pass_cnt),
        .FailCnt (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic pass;
        logic fail;
        logic tmo;
        int   pcnt;
        int   fcnt;
        int   wlen;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0, n_err = 0;
    int   run_pulses = 0, results_seen = 0;
    int   m_pcnt = 0, m_fcnt = 0;
    int   done_delay = -1;
    logic rslt_val = 1'b0;
    logic sticky = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Checker model: drops Done on Run (unless sticky), raises Done/RSLT done_delay cycles later
    initial begin : checker_model
        int cnt;
        cnt = -1;
        cif.Done = 1'b0;
        cif.RSLT = 1'b0;
        forever begin
            @(negedge clk);
            if (cif.Run) begin
                if (!sticky) cif.Done = 1'b0;
                cnt = done_delay;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    cif.Done = 1'b1;
                    cif.RSLT = rslt_val;
                end
            end
        end
    end

    initial begin : monitor
        logic prev_busy;
        int   wlen, run_len;
        exp_t e;
        prev_busy = 1'b0;
        wlen = 0;
        run_len = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_busy = 1'b0;
                wlen = 0;
                run_len = 0;
            end else begin
                if (cif.Run) run_len++;
                else if (run_len > 0) begin
                    check("run_width", run_len, 1);
                    run_pulses++;
                    run_len = 0;
                end
                if (busy && cif.DISP_RSLT) wlen++;
                if (prev_busy && !busy) begin
                    check("sb_pending", sb_q.size() > 0, 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check("pass", pass, e.pass);
                        check("fail", fail, e.fail);
                        check("timeout", tmo, e.tmo);
                        check("pass_cnt", pass_cnt, e.pcnt);
                        check("fail_cnt", fail_cnt, e.fcnt);
                        check("wait_len", wlen, e.wlen);
                        check("disp_show", cif.DISP_RSLT, 1);
                    end
                    wlen = 0;
                    results_seen++;
                end
                prev_busy = busy;
            end
        end
    end

    // d < 0: checker never answers
    task automatic run_test(input int d, input logic r, input logic stk,
                            input logic poke, input logic with_clr);
        exp_t e;
        int   seen0, runs0;
        logic got;
        if (with_clr) begin
            m_pcnt = 0;
            m_fcnt = 0;
        end
        e.tmo  = (d < 0) || (d > int'(TMO));
        e.pass = !e.tmo && r;
        e.fail = !e.tmo && !r;
        if (e.pass) m_pcnt = (m_pcnt < CNT_TOP) ? m_pcnt + 1 : m_pcnt;
        else        m_fcnt = (m_fcnt < CNT_TOP) ? m_fcnt + 1 : m_fcnt;
        e.pcnt = m_pcnt;
        e.fcnt = m_fcnt;
        e.wlen = e.tmo ? int'(TMO) : d;
        sb_q.push_back(e);

        done_delay = d;
        rslt_val   = r;
        sticky     = stk;
        seen0      = results_seen;
        runs0      = run_pulses;

        start = 1'b1;
        clear = with_clr;
        repeat (3) @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        if (poke) begin
            for (int i = 0; i < 20 && !cif.Run; i++) @(negedge clk);
            repeat (2) @(negedge clk);
            start = 1'b1;
            clear = 1'b1;
            repeat (2) @(negedge clk);
            start = 1'b0;
            clear = 1'b0;
        end

        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = (results_seen != seen0);
        end
        check("result_seen", got, 1);
        check("run_count", run_pulses - runs0, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_run"}, cif.Run, 0);
        check({tag, "_disp"}, cif.DISP_RSLT, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_fail"}, fail, 0);
        check({tag, "_tmo"}, tmo, 0);
        check({tag, "_pcnt"}, pass_cnt, 0);
        check({tag, "_fcnt"}, fail_cnt, 0);
        check({tag, "_state"}, int'(dut.state), int'(IDLE));
    endtask

    initial begin : watchdog
        #600_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        int runs0;
        rst   = 1'b1;
        start = 1'b0;
        clear = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_quiet("reset");

        run_test(5, 1'b1, 1'b0, 1'b0, 1'b0);   // basic pass
        run_test(-1, 1'b0, 1'b0, 1'b0, 1'b0);  // timeout
        run_test(3, 1'b0, 1'b0, 1'b0, 1'b0);   // fail, leaves Done=1/RSLT=0 held
        run_test(2, 1'b1, 1'b1, 1'b0, 1'b0);   // stale Done ignored in first WAIT cycle
        run_test(TMO, 1'b1, 1'b0, 1'b0, 1'b0); // Done on the last cycle beats timeout
        run_test(8, 1'b0, 1'b0, 1'b1, 1'b0);   // Start/Clear during WAIT ignored

        for (int n = 0; n < 260; n++) begin
            run_test(int'($urandom_range(2, 10)), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check("pcnt_saturated", pass_cnt, CNT_TOP);

        clear = 1'b1;
        repeat (3) @(negedge clk);
        clear = 1'b0;
        repeat (3) @(negedge clk);
        m_pcnt = 0;
        m_fcnt = 0;
        check("clr_pcnt", pass_cnt, 0);
        check("clr_fcnt", fail_cnt, 0);
        check("clr_pass_kept", pass, 1);
        check("clr_busy", busy, 0);

        run_test(4, 1'b1, 1'b0, 1'b0, 1'b0);
        run_test(6, 1'b1, 1'b0, 1'b0, 1'b0);
        run_test(4, 1'b0, 1'b0, 1'b0, 1'b1);   // Clear+Start together in SHOW

        // Reset while waiting on a silent checker
        runs0      = run_pulses;
        done_delay = -1;
        sticky     = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !cif.Run; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check_quiet("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_pcnt = 0;
        m_fcnt = 0;
        repeat (20) @(negedge clk);
        check("post_rst_runs", run_pulses - runs0, 1);
        check_quiet("post_rst");

        run_test(3, 1'b1, 1'b0, 1'b0, 1'b0);
        check("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
